// File: rtl/flit_output_arbiter_pkg.sv
// Shared definitions for the router output-port arbiter: default sizes,
// flit type encodings and the arbiter FSM state type.
// Pure package; no logic, no latency, no flow control of its own.
package flit_output_arbiter_pkg;

  localparam int N_IN   = 4;   // input buffers arbitrated
  localparam int FLIT_W = 10;  // flit width, type in the top two bits
  localparam int PTR_W  = 2;   // grant index / round-robin pointer width
  localparam int TYPE_W = 2;   // width of the flit type field at the MSBs

  typedef logic [TYPE_W-1:0] flit_type_t;

  localparam flit_type_t FLIT_HEAD   = 2'b10;
  localparam flit_type_t FLIT_BODY   = 2'b00;
  localparam flit_type_t FLIT_TAIL   = 2'b01;
  localparam flit_type_t FLIT_SINGLE = 2'b11;

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  // A flit that may open a packet (and so may win arbitration).
  function automatic logic is_opener(input flit_type_t t);
    return (t == FLIT_HEAD) || (t == FLIT_SINGLE);
  endfunction

  // A flit that closes a packet (and so releases the wormhole lock).
  function automatic logic is_closer(input flit_type_t t);
    return (t == FLIT_TAIL) || (t == FLIT_SINGLE);
  endfunction

endpackage

// File: rtl/flit_output_arbiter_if.sv
// Flit streams between the per-input buffers, the output arbiter and the link.
// Wires only; no latency.
// valid/ready per input toward the buffers, valid/ready on the single output.
// Ports: valid_in/data_in/ready_out face the input buffers,
//        data_out/valid_out/ready_in face the link or next router.
interface flit_output_arbiter_if
  #(parameter int N_IN   = flit_output_arbiter_pkg::N_IN,
    parameter int FLIT_W = flit_output_arbiter_pkg::FLIT_W);

  logic [N_IN-1:0]        valid_in;
  logic [N_IN*FLIT_W-1:0] data_in;
  logic [N_IN-1:0]        ready_out;
  logic [FLIT_W-1:0]      data_out;
  logic                   valid_out;
  logic                   ready_in;

  // Arbiter side.
  modport slave (
    input  valid_in, data_in, ready_in,
    output ready_out, data_out, valid_out
  );

  // Buffer/link side (stimulus and sink).
  modport master (
    output valid_in, data_in, ready_in,
    input  ready_out, data_out, valid_out
  );

endinterface

// File: rtl/flit_output_arbiter_rr_arbiter.sv
// Round-robin pick: first asserted request scanning from rr_ptr upward, modulo N_IN.
// Combinational, zero cycles.
// No flow control; the caller decides when the pick is used.
// Ports: req (request vector), rr_ptr (scan start, must be < N_IN),
//        grant_idx (picked input), any_grant (at least one request).
module rr_arbiter #(
  parameter int N_IN  = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_IN-1:0]  req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [PTR_W-1:0] grant_idx,
  output logic             any_grant
);

  // One extra bit so rr_ptr + k can exceed N_IN-1 before being folded back.
  logic [PTR_W:0] idx;

  always_comb begin
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = '0;
    for (int k = 0; k < N_IN; k++) begin
      idx = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (idx >= (PTR_W+1)'(N_IN)) begin
        idx = idx - (PTR_W+1)'(N_IN);
      end
      if (!any_grant && req[idx[PTR_W-1:0]]) begin
        grant_idx = idx[PTR_W-1:0];
        any_grant = 1'b1;
      end
    end
  end

endmodule

// File: rtl/flit_output_arbiter.sv
// Router output port: round-robin arbitration between packets with wormhole locking.
// Latency: 1 arbitration cycle, then 1 cycle input-to-data_out; bodies stream 1/cycle.
// Backpressure: ready_in=0 with a held flit freezes data_out and drops every ready_out.
// Ports: clk, reset (async, active low), bus (slave modport):
//        valid_in/data_in/ready_out to the input buffers, data_out/valid_out/ready_in to the link.
module flit_output_arbiter
  import flit_output_arbiter_pkg::*;
#(
  parameter int N_IN   = flit_output_arbiter_pkg::N_IN,
  parameter int FLIT_W = flit_output_arbiter_pkg::FLIT_W,
  parameter int PTR_W  = flit_output_arbiter_pkg::PTR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  flit_output_arbiter_if.slave  bus
);

  state_t            state, state_nxt;
  logic [PTR_W-1:0]  grant, grant_nxt;
  logic [PTR_W-1:0]  rr_ptr, rr_ptr_nxt;

  logic [FLIT_W-1:0] flits [N_IN];
  logic [N_IN-1:0]   req;
  logic [PTR_W-1:0]  pick;
  logic              any_pick;

  logic [FLIT_W-1:0] cur_flit;
  flit_type_t        cur_type;
  logic              adv;
  logic              load;
  logic [N_IN-1:0]   ready_out_c;

  logic [FLIT_W-1:0] data_q;
  logic              valid_q;

  // Unpack inputs and flag those presenting a packet opener.
  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      flits[i] = bus.data_in[i*FLIT_W +: FLIT_W];
      req[i]   = bus.valid_in[i] && is_opener(flits[i][FLIT_W-1 -: TYPE_W]);
    end
  end

  rr_arbiter #(
    .N_IN  (N_IN),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req       (req),
    .rr_ptr    (rr_ptr),
    .grant_idx (pick),
    .any_grant (any_pick)
  );

  assign cur_flit = flits[grant];
  assign cur_type = cur_flit[FLIT_W-1 -: TYPE_W];

  // Output register can take a new flit when empty or draining this cycle.
  assign adv  = !valid_q || bus.ready_in;
  assign load = (state == LOCKED) && bus.valid_in[grant] && adv;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    rr_ptr_nxt  = rr_ptr;
    ready_out_c = '0;
    case (state)
      IDLE: begin
        // Arbitration cycle: nothing pops, the winner is latched for next cycle.
        if (any_pick) begin
          grant_nxt = pick;
          state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        // Pop is offered regardless of valid_in so the buffer sees a plain ready.
        ready_out_c[grant] = adv;
        if (load && is_closer(cur_type)) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = (grant == PTR_W'(N_IN-1)) ? '0 : grant + PTR_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      data_q  <= cur_flit;
      valid_q <= 1'b1;
    end else if (adv) begin
      // Drained (or was empty) with nothing new: data_out keeps its last value.
      valid_q <= 1'b0;
    end
  end

  assign bus.ready_out = ready_out_c;
  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;

endmodule

// File: tb/tb_flit_output_arbiter.sv
// Directed bench for flit_output_arbiter: per-cycle vector table plus a hand-written reset sequence.
// Inputs are driven at the falling edge, outputs sampled 1 ns later.
// Each row lists the inputs for one cycle and the outputs expected during that cycle.
module tb_flit_output_arbiter;
  import flit_output_arbiter_pkg::*;

  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  flit_output_arbiter_if #(.N_IN(4), .FLIT_W(10)) bus ();

  flit_output_arbiter #(.N_IN(4), .FLIT_W(10), .PTR_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  vin;
    logic [39:0] din;
    logic        rin;
    logic [3:0]  ro;
    logic        vo;
    logic [9:0]  dout;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   g_single, g_prereset, g_contend, g_end;

  function automatic logic [39:0] pk(input logic [9:0] d0, input logic [9:0] d1,
                                     input logic [9:0] d2, input logic [9:0] d3);
    return {d3, d2, d1, d0};
  endfunction

  task automatic add(input logic [3:0] vin, input logic [39:0] din, input logic rin,
                     input logic [3:0] ro, input logic vo, input logic [9:0] dout);
    vec_t v;
    v.vin = vin; v.din = din; v.rin = rin;
    v.ro = ro; v.vo = vo; v.dout = dout;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got %0h, expected %0h", name, id, act, exp);
    end
  endtask

  task automatic run(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      @(negedge clk);
      bus.valid_in = vecs[i].vin;
      bus.data_in  = vecs[i].din;
      bus.ready_in = vecs[i].rin;
      #1;
      chk("ready_out", i, 32'(bus.ready_out), 32'(vecs[i].ro));
      chk("valid_out", i, 32'(bus.valid_out), 32'(vecs[i].vo));
      chk("data_out",  i, 32'(bus.data_out),  32'(vecs[i].dout));
    end
  endtask

  initial begin
    // Single 3-flit packet on input 2 from a fresh reset.
    add(4'b0100, pk(0, 0, 10'h2A5, 0), 1, 4'b0000, 0, 10'h000);
    add(4'b0100, pk(0, 0, 10'h2A5, 0), 1, 4'b0100, 0, 10'h000);
    add(4'b0100, pk(0, 0, 10'h011, 0), 1, 4'b0100, 1, 10'h2A5);
    add(4'b0100, pk(0, 0, 10'h133, 0), 1, 4'b0100, 1, 10'h011);
    add(4'b0000, pk(0, 0, 0, 0),       1, 4'b0000, 1, 10'h133);
    add(4'b0000, pk(0, 0, 0, 0),       1, 4'b0000, 0, 10'h133);
    g_single = vecs.size();
    // Heads on every input with rr_ptr=3: input 3 wins, then reset lands mid-packet.
    add(4'b1111, pk(10'h201, 10'h202, 10'h203, 10'h204), 1, 4'b0000, 0, 10'h133);
    add(4'b1111, pk(10'h201, 10'h202, 10'h203, 10'h204), 1, 4'b1000, 0, 10'h133);
    add(4'b1111, pk(10'h201, 10'h202, 10'h203, 10'h204), 1, 4'b1000, 1, 10'h204);
    g_prereset = vecs.size();
    // Contention: inputs 0 and 3 together after reset, input 0 first, no interleave.
    add(4'b1001, pk(10'h2A1, 0, 0, 10'h2B3), 1, 4'b0000, 0, 10'h000);
    add(4'b1001, pk(10'h2A1, 0, 0, 10'h2B3), 1, 4'b0001, 0, 10'h000);
    add(4'b1001, pk(10'h012, 0, 0, 10'h2B3), 1, 4'b0001, 1, 10'h2A1);
    add(4'b1001, pk(10'h141, 0, 0, 10'h2B3), 1, 4'b0001, 1, 10'h012);
    add(4'b1000, pk(0, 0, 0, 10'h2B3),       1, 4'b0000, 1, 10'h141);
    add(4'b1000, pk(0, 0, 0, 10'h2B3),       1, 4'b1000, 0, 10'h141);
    add(4'b1000, pk(0, 0, 0, 10'h023),       1, 4'b1000, 1, 10'h2B3);
    add(4'b1000, pk(0, 0, 0, 10'h153),       1, 4'b1000, 1, 10'h023);
    add(4'b0000, pk(0, 0, 0, 0),             1, 4'b0000, 1, 10'h153);
    g_contend = vecs.size();
    // Backpressure: body held for 3 cycles, tail follows once ready_in returns.
    add(4'b0001, pk(10'h2A5, 0, 0, 0), 1, 4'b0000, 0, 10'h153);
    add(4'b0001, pk(10'h2A5, 0, 0, 0), 1, 4'b0001, 0, 10'h153);
    add(4'b0001, pk(10'h011, 0, 0, 0), 1, 4'b0001, 1, 10'h2A5);
    add(4'b0001, pk(10'h133, 0, 0, 0), 0, 4'b0000, 1, 10'h011);
    add(4'b0001, pk(10'h133, 0, 0, 0), 0, 4'b0000, 1, 10'h011);
    add(4'b0001, pk(10'h133, 0, 0, 0), 0, 4'b0000, 1, 10'h011);
    add(4'b0001, pk(10'h133, 0, 0, 0), 1, 4'b0001, 1, 10'h011);
    add(4'b0000, pk(0, 0, 0, 0),       1, 4'b0000, 1, 10'h133);
    // Single-flit fairness: input 2's packet goes between input 1's two singles.
    add(4'b0110, pk(0, 10'h3C4, 10'h2C2, 0), 1, 4'b0000, 0, 10'h133);
    add(4'b0110, pk(0, 10'h3C4, 10'h2C2, 0), 1, 4'b0010, 0, 10'h133);
    add(4'b0110, pk(0, 10'h3C5, 10'h2C2, 0), 1, 4'b0000, 1, 10'h3C4);
    add(4'b0110, pk(0, 10'h3C5, 10'h2C2, 0), 1, 4'b0100, 0, 10'h3C4);
    add(4'b0110, pk(0, 10'h3C5, 10'h1C2, 0), 1, 4'b0100, 1, 10'h2C2);
    add(4'b0010, pk(0, 10'h3C5, 0, 0),       1, 4'b0000, 1, 10'h1C2);
    add(4'b0010, pk(0, 10'h3C5, 0, 0),       1, 4'b0010, 0, 10'h1C2);
    add(4'b0000, pk(0, 0, 0, 0),             1, 4'b0000, 1, 10'h3C5);
    add(4'b0000, pk(0, 0, 0, 0),             1, 4'b0000, 0, 10'h3C5);
    // Bubble: input 0 pauses 2 cycles, lock held, input 3's head waits.
    add(4'b0001, pk(10'h2A5, 0, 0, 0),       1, 4'b0000, 0, 10'h3C5);
    add(4'b1001, pk(10'h2A5, 0, 0, 10'h2B3), 1, 4'b0001, 0, 10'h3C5);
    add(4'b1001, pk(10'h011, 0, 0, 10'h2B3), 1, 4'b0001, 1, 10'h2A5);
    add(4'b1000, pk(0, 0, 0, 10'h2B3),       1, 4'b0001, 1, 10'h011);
    add(4'b1000, pk(0, 0, 0, 10'h2B3),       1, 4'b0001, 0, 10'h011);
    add(4'b1001, pk(10'h133, 0, 0, 10'h2B3), 1, 4'b0001, 0, 10'h011);
    add(4'b1000, pk(0, 0, 0, 10'h2B3),       1, 4'b0000, 1, 10'h133);
    add(4'b1000, pk(0, 0, 0, 10'h2B3),       1, 4'b1000, 0, 10'h133);
    add(4'b1000, pk(0, 0, 0, 10'h153),       1, 4'b1000, 1, 10'h2B3);
    add(4'b0000, pk(0, 0, 0, 0),             1, 4'b0000, 1, 10'h153);
    // A body flit at input 1 while idle is never granted.
    add(4'b0010, pk(0, 10'h011, 0, 0), 1, 4'b0000, 0, 10'h153);
    add(4'b0010, pk(0, 10'h011, 0, 0), 1, 4'b0000, 0, 10'h153);
    add(4'b0010, pk(0, 10'h011, 0, 0), 1, 4'b0000, 0, 10'h153);
    g_end = vecs.size();

    // Power-on reset.
    reset        = 1'b0;
    bus.valid_in = '0;
    bus.data_in  = '0;
    bus.ready_in = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset ready_out", -1, 32'(bus.ready_out), 32'h0);
    chk("reset valid_out", -1, 32'(bus.valid_out), 32'h0);
    chk("reset data_out",  -1, 32'(bus.data_out),  32'h0);
    chk("reset rr_ptr",    -1, 32'(dut.rr_ptr),    32'h0);
    @(posedge clk);
    #2 reset = 1'b1;

    run(0, g_single);
    chk("rr_ptr after input 2 packet", -2, 32'(dut.rr_ptr), 32'h3);

    run(g_single, g_prereset);

    // Mid-packet asynchronous reset with all inputs requesting.
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("async reset valid_out", -3, 32'(bus.valid_out), 32'h0);
    chk("async reset data_out",  -3, 32'(bus.data_out),  32'h0);
    chk("async reset ready_out", -3, 32'(bus.ready_out), 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk("held reset ready_out", -4 - c, 32'(bus.ready_out), 32'h0);
      chk("held reset valid_out", -4 - c, 32'(bus.valid_out), 32'h0);
    end
    chk("held reset rr_ptr", -7, 32'(dut.rr_ptr), 32'h0);
    @(posedge clk);
    #2 reset = 1'b1;

    run(g_prereset, g_contend);
    chk("rr_ptr after contention wrap", -8, 32'(dut.rr_ptr), 32'h0);

    run(g_contend, g_end);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/flit_output_arbiter.md
Name: flit_output_arbiter

Overview:
- Router output-port stage, directly downstream of the per-input elastic buffers.
- Takes the valid/data/ready streams of N_IN input buffers and grants one input at a time with wormhole locking: a granted packet holds the port from head flit to tail flit.
- Arbitration between packets is round-robin.
- Drives one registered flit stream (data_out/valid_out, backpressured by ready_in) toward the link or next router.

Parameters:
- N_IN, 4, number of input buffers arbitrated.
- FLIT_W, 10, flit width; bits [FLIT_W-1:FLIT_W-2] are the flit type, the rest is payload.
- PTR_W, 2, width of grant index and round-robin pointer; must satisfy 2^PTR_W >= N_IN.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- valid_in  input  N_IN  per-input flit valid, from each buffer's valid_out.
- data_in  input  N_IN*FLIT_W  packed flits; input i occupies [i*FLIT_W +: FLIT_W].
- ready_out  output  N_IN  per-input pop enable, to each buffer's ready_in.
- data_out  output  FLIT_W  registered outgoing flit.
- valid_out  output  1  data_out holds a flit.
- ready_in  input  1  downstream can accept.

Behaviour:
- Flit type encoding (top 2 bits):
  - 2'b10 head.
  - 2'b00 body.
  - 2'b01 tail.
  - 2'b11 single (head+tail).
- Reset (reset=0, async):
  - state=IDLE, rr_ptr=0, grant=0.
  - valid_out=0, data_out=0, ready_out=0.
- Output register:
  - adv = !valid_out || ready_in.
  - Downstream transfer occurs when valid_out && ready_in.
- FSM, two states:
  - IDLE:
    - ready_out=0.
    - Candidates are inputs i with valid_in[i]=1 and type head or single.
    - Pick the first candidate scanning rr_ptr, rr_ptr+1, ... modulo N_IN.
    - If any candidate exists: grant<=pick, go to LOCKED at the next edge.
    - No flit moves in the arbitration cycle, so arbitration costs 1 cycle.
  - LOCKED:
    - ready_out[grant] = adv; all other ready_out bits are 0.
    - ready_out does not depend on valid_in.
    - Load when valid_in[grant] && adv: data_out<=flit, valid_out<=1.
    - Flit type tail or single loaded: state<=IDLE, rr_ptr<=(grant+1) mod N_IN.
    - Otherwise stay LOCKED. A bubble (valid_in[grant]=0) keeps the lock.
  - If nothing is loaded while adv=1 (any state): valid_out<=0.
- Latency:
  - Head visible at a buffer in IDLE: grant at edge 1, flit loaded at edge 2, valid_out=1 after edge 2.
  - With ready_in=1, body flits stream one per cycle with no bubbles.
- Backpressure:
  - ready_in=0 with valid_out=1: data_out and valid_out hold, all ready_out=0, no pop.
- Wrap-around: rr_ptr = N_IN-1 wraps to 0.
- Simultaneous events:
  - A tail load and new head candidates in the same cycle: new arbitration happens only in the following IDLE cycle, one-cycle gap at the input side.
  - The output register may still drain during IDLE.
- Protocol violations:
  - A body/tail flit at an input while IDLE is never granted; it stalls that input.
  - A head flit while LOCKED on that input is passed through as data; the lock releases only on tail or single.
- Reset mid-packet: all outputs clear immediately, and any partial packet already sent is abandoned.

Decomposition:
- Shared package holds:
  - FLIT_W.
  - Flit type constants: FLIT_HEAD=2'b10, FLIT_BODY=2'b00, FLIT_TAIL=2'b01, FLIT_SINGLE=2'b11.
  - Type field position.
  - The buffer is reused from it too.
- One sub-module: rr_arbiter.
  - Combinational.
  - Inputs: request vector, rr_ptr.
  - Outputs: grant index, any_grant.
- FSM, output register and data mux live in the top.

Test Plan:
- Reset: drive reset=0 mid-simulation with valid_in=4'b1111 -> valid_out=0, data_out=0, ready_out=0000 immediately; no grant until reset=1.
- Single packet on input 2: head 10'h2A5, body 10'h011, tail 10'h133, ready_in=1 -> ready_out=0100 for 3 cycles, data_out=2A5,011,133 on consecutive cycles starting 2 edges after the head appears; then IDLE, rr_ptr=3.
- Contention: heads on inputs 0 and 3 at the same cycle, rr_ptr=0, each a 3-flit packet -> input 0's flits all delivered before any flit of input 3; no interleaving; final rr_ptr=0 (wrap from 3).
- Backpressure: ready_in=0 for 3 cycles while body 10'h011 sits in data_out -> data_out=011 and valid_out=1 held, ready_out=0000; resumes with the tail on the cycle after ready_in=1.
- Single-flit fairness: input 1 sends 10'h3C4, then another single; input 2 has a head pending -> after 3C4, input 2's packet is granted before input 1's second flit.
- Bubble in packet: input 0 deasserts valid_in for 2 cycles between body and tail -> lock held, input 3 head not granted, valid_out drops once drained, tail follows when valid_in returns.
